// File: rtl/dtw_row_engine.sv
// dtw_row_engine: streaming DTW accumulator over a row-major R x C cost
// matrix. One previous row is kept in a buffer. Each accepted distance
// produces one registered cell carrying the accumulated value, the path code
// and row-end and matrix-end flags.
//
// Handshake rules, identical on both streams: a transfer happens on a rising
// edge where valid & ready are both high. A producer holding valid high keeps
// its payload stable until the transfer. dist_ready depends only on state,
// cell_valid and cell_ready, and never on dist_valid.
module dtw_row_engine #(
  parameter int DIST_W   = 8,
  parameter int DTW_W    = 16,
  parameter int MAX_COLS = 64,
  parameter int ROW_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(MAX_COLS):0]   num_cols,
  input  logic [ROW_W-1:0]            num_rows,
  input  logic                        dist_valid,
  input  logic [DIST_W-1:0]           dist_data,
  output logic                        dist_ready,
  output logic                        cell_valid,
  input  logic                        cell_ready,
  output logic [DTW_W-1:0]            cell_dtw,
  output logic [1:0]                  cell_dir,
  output logic                        cell_eol,
  output logic                        cell_last,
  output logic                        busy,
  output logic                        done,
  output logic [DTW_W-1:0]            result
);

  localparam int CW    = $clog2(MAX_COLS) + 1;
  localparam int AW    = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [CW-1:0]    MAX_C = CW'(MAX_COLS);
  localparam logic [DTW_W-1:0] INF   = '1;

  localparam logic [1:0] DIR_DIAG = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_LEFT = 2'b10;
  localparam logic [1:0] DIR_ORIG = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;

  // The FSM state is a plain named signal so checkers can bind to it.
  state_t state;
  state_t state_nx;

  logic [CW-1:0]    cols_r;
  logic [ROW_W-1:0] rows_r;
  logic [ROW_W-1:0] i_r;
  logic [CW-1:0]    j_r;
  logic [DTW_W-1:0] left_r;
  logic [DTW_W-1:0] diag_r;
  logic [DTW_W-1:0] row_buf [DEPTH];

  logic             start_ok;
  logic             dist_acc;
  logic             col_end;
  logic             row_end;
  logic             last_cell;

  logic [DTW_W-1:0] up_v;
  logic [DTW_W-1:0] diag_v;
  logic [DTW_W-1:0] left_v;
  logic [DTW_W-1:0] a_v;
  logic [1:0]       a_dir;
  logic [DTW_W-1:0] m_v;
  logic [1:0]       m_dir;
  logic [DTW_W:0]   d_ext;
  logic [DTW_W:0]   sum;
  logic [DTW_W-1:0] d_val;
  logic [1:0]       d_dir;

  // A start is accepted only when the arguments describe a real matrix.
  assign start_ok  = start && (num_cols != '0) && (num_cols <= MAX_C) &&
                     (num_rows != '0);
  assign dist_ready = (state == RUN) && (!cell_valid || cell_ready);
  assign dist_acc  = dist_valid && dist_ready;
  assign col_end   = (j_r == cols_r - 1'b1);
  assign row_end   = (i_r == rows_r - 1'b1);
  assign last_cell = col_end && row_end;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: DONE lasts exactly one cycle; start is ignored outside IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = RUN;
      RUN:     if (dist_acc && last_cell) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Cell computation: mask missing predecessors to INF, pick the minimum
  // with the left-over-diag and up-over-both tie order, then saturating add.
  always_comb begin
    up_v   = (i_r == '0) ? INF : row_buf[j_r[AW-1:0]];
    diag_v = ((i_r == '0) || (j_r == '0)) ? INF : diag_r;
    left_v = (j_r == '0) ? INF : left_r;
    if (diag_v < left_v) begin
      a_v   = diag_v;
      a_dir = DIR_DIAG;
    end else begin
      a_v   = left_v;
      a_dir = DIR_LEFT;
    end
    if (a_v < up_v) begin
      m_v   = a_v;
      m_dir = a_dir;
    end else begin
      m_v   = up_v;
      m_dir = DIR_UP;
    end
    d_ext              = '0;
    d_ext[DIST_W-1:0]  = dist_data;
    sum                = {1'b0, m_v} + d_ext;
    if ((i_r == '0) && (j_r == '0)) begin
      d_val = d_ext[DTW_W-1:0];
      d_dir = DIR_ORIG;
    end else begin
      d_val = sum[DTW_W] ? INF : sum[DTW_W-1:0];
      d_dir = m_dir;
    end
  end

  // Run arguments and row/column position within the matrix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cols_r <= '0;
      rows_r <= '0;
      i_r    <= '0;
      j_r    <= '0;
    end else if ((state == IDLE) && start_ok) begin
      cols_r <= num_cols;
      rows_r <= num_rows;
      i_r    <= '0;
      j_r    <= '0;
    end else if (dist_acc) begin
      if (col_end) begin
        j_r <= '0;
        i_r <= i_r + 1'b1;
      end else begin
        j_r <= j_r + 1'b1;
      end
    end
  end

  // Left and diagonal predecessors; diag takes the up value just consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_r <= '0;
      diag_r <= '0;
    end else if (dist_acc) begin
      left_r <= d_val;
      diag_r <= up_v;
    end
  end

  // Row buffer: slot j always holds the newest value of column j.
  always_ff @(posedge clk) begin
    if (dist_acc) row_buf[j_r[AW-1:0]] <= d_val;
  end

  // Single-entry output register, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cell_valid <= 1'b0;
      cell_dtw   <= '0;
      cell_dir   <= 2'b00;
      cell_eol   <= 1'b0;
      cell_last  <= 1'b0;
    end else if (dist_acc) begin
      cell_valid <= 1'b1;
      cell_dtw   <= d_val;
      cell_dir   <= d_dir;
      cell_eol   <= col_end;
      cell_last  <= last_cell;
    end else if (cell_ready) begin
      cell_valid <= 1'b0;
    end
  end

  // Final matrix value, kept until overwritten by the next run's last cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        result <= '0;
    else if (dist_acc && last_cell) result <= d_val;
  end

endmodule

// File: tb/tb_dtw_row_engine.sv
// tb_dtw_row_engine: directed and randomized runs of dtw_row_engine with a
// full-matrix reference model feeding an expected-cell queue and a monitor
// that checks every presented cell and every done pulse.
module tb_dtw_row_engine;
  localparam int DIST_W   = 8;
  localparam int DTW_W    = 8;
  localparam int MAX_COLS = 8;
  localparam int ROW_W    = 8;
  localparam int CW       = $clog2(MAX_COLS) + 1;
  localparam int EW       = DTW_W + 4;
  localparam int DMAX     = (1 << DTW_W) - 1;
  localparam int INF      = DMAX;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CW-1:0]     num_cols = '0;
  logic [ROW_W-1:0]  num_rows = '0;
  logic              dist_valid = 1'b0;
  logic [DIST_W-1:0] dist_data = '0;
  logic              dist_ready;
  logic              cell_valid;
  logic              cell_ready = 1'b1;
  logic [DTW_W-1:0]  cell_dtw;
  logic [1:0]        cell_dir;
  logic              cell_eol;
  logic              cell_last;
  logic              busy;
  logic              done;
  logic [DTW_W-1:0]  result;

  dtw_row_engine #(
    .DIST_W(DIST_W), .DTW_W(DTW_W), .MAX_COLS(MAX_COLS), .ROW_W(ROW_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_cols(num_cols),
    .num_rows(num_rows), .dist_valid(dist_valid), .dist_data(dist_data),
    .dist_ready(dist_ready), .cell_valid(cell_valid), .cell_ready(cell_ready),
    .cell_dtw(cell_dtw), .cell_dir(cell_dir), .cell_eol(cell_eol),
    .cell_last(cell_last), .busy(busy), .done(done), .result(result)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]    exp_q[$];
  logic [DTW_W-1:0] res_q[$];
  logic [DTW_W-1:0] last_res = '0;
  int               dq[$];
  int               checks = 0;
  int               errors = 0;
  int               stall_left = 0;
  bit               rand_bp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int v, input int dir, input bit eol, input bit last);
    logic [EW-1:0] e;
    e = {DTW_W'(v), 2'(dir), eol, last};
    exp_q.push_back(e);
  endtask

  // Full-matrix DTW reference: fills the whole cost matrix from dq.
  task automatic model_push(input int r, input int c);
    int dm [8][8];
    int up, dg, lf, a, ac, m, mc, v, dir;
    for (int i = 0; i < r; i++) begin
      for (int j = 0; j < c; j++) begin
        if (i == 0 && j == 0) begin
          v = dq[0];
          dir = 3;
        end else begin
          dg = (i > 0 && j > 0) ? dm[i-1][j-1] : INF;
          up = (i > 0) ? dm[i-1][j] : INF;
          lf = (j > 0) ? dm[i][j-1] : INF;
          if (dg < lf) begin a = dg; ac = 0; end
          else begin a = lf; ac = 2; end
          if (a < up) begin m = a; mc = ac; end
          else begin m = up; mc = 1; end
          v = dq[i*c+j] + m;
          if (v > DMAX) v = DMAX;
          dir = mc;
        end
        dm[i][j] = v;
        push_exp(v, dir, (j == c-1), (i == r-1) && (j == c-1));
      end
    end
    res_q.push_back(DTW_W'(dm[r-1][c-1]));
  endtask

  // ---------------- downstream ready generator ----------------
  always @(posedge clk) begin
    #2;
    if (stall_left > 0) begin
      cell_ready = 1'b0;
      stall_left--;
    end else begin
      cell_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (cell_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cell", cell_valid, 0);
        end else begin
          chk("cell", {cell_dtw, cell_dir, cell_eol, cell_last}, exp_q[0]);
          if (cell_ready) void'(exp_q.pop_front());
          else chk("stall_dist_ready", dist_ready, 0);
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          chk("result", result, res_q[0]);
          last_res = res_q.pop_front();
          chk("done_with_last", {cell_valid, cell_last}, 2'b11);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int c, input int r);
    start = 1'b1;
    num_cols = CW'(c);
    num_rows = ROW_W'(r);
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int stall_at, input int restart_at, input int abort_at,
                        output int first, output int last);
    int guard;
    bit acc;
    first = 0;
    last = 0;
    for (int k = 0; k < dq.size(); k++) begin
      if (k == abort_at) begin
        dist_valid = 1'b0;
        start = 1'b0;
        return;
      end
      if (k == stall_at) stall_left = 3;
      if (k == restart_at) begin
        start = 1'b1;
        num_cols = CW'(1);
        num_rows = ROW_W'(1);
      end else begin
        start = 1'b0;
      end
      dist_valid = 1'b1;
      dist_data = DIST_W'(dq[k]);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        @(negedge clk);
        if (dist_ready) begin
          acc = 1'b1;
          if (k == 0) first = cyc;
          last = cyc;
        end
        tick();
        guard++;
      end
      if (!acc) begin
        chk("dist_accept_timeout", dist_ready, 1);
        dist_valid = 1'b0;
        start = 1'b0;
        return;
      end
    end
    dist_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 60) begin
      tick();
      g++;
    end
    if (busy) chk("idle_timeout", busy, 0);
    else chk("result_held", result, last_res);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dist_ready"}, dist_ready, 0);
    chk({tag, "_cell_valid"}, cell_valid, 0);
    chk({tag, "_cell_dtw"}, cell_dtw, 0);
    chk({tag, "_cell_dir"}, cell_dir, 0);
    chk({tag, "_cell_eol"}, cell_eol, 0);
    chk({tag, "_cell_last"}, cell_last, 0);
    chk({tag, "_result"}, result, 0);
  endtask

  task automatic fill_rand(input int n, input int dmax);
    dq.delete();
    for (int k = 0; k < n; k++) dq.push_back(int'($urandom_range(0, dmax)));
  endtask

  task automatic run_model(input int r, input int c, input int dmax,
                           input int stall_at, input int restart_at);
    int f, l;
    fill_rand(r * c, dmax);
    model_push(r, c);
    do_start(c, r);
    chk("busy_after_start", busy, 1);
    stream(stall_at, restart_at, -1, f, l);
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int f, l;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // 2x2 worked example at full throughput.
    dq = '{1, 3, 2, 1};
    push_exp(1, 3, 0, 0); push_exp(4, 2, 1, 0);
    push_exp(3, 1, 0, 0); push_exp(2, 0, 1, 1);
    res_q.push_back(DTW_W'(2));
    do_start(2, 2);
    chk("busy_after_start", busy, 1);
    stream(-1, -1, -1, f, l);
    chk("throughput", l - f, 3);
    wait_idle();

    // 2x2 all zeros: ties resolve toward up, then left.
    dq = '{0, 0, 0, 0};
    push_exp(0, 3, 0, 0); push_exp(0, 2, 1, 0);
    push_exp(0, 1, 0, 0); push_exp(0, 1, 1, 1);
    res_q.push_back(DTW_W'(0));
    do_start(2, 2);
    stream(-1, -1, -1, f, l);
    wait_idle();

    // 1x2 saturation.
    dq = '{200, 100};
    push_exp(200, 3, 0, 0); push_exp(255, 2, 1, 1);
    res_q.push_back(DTW_W'(255));
    do_start(2, 1);
    stream(-1, -1, -1, f, l);
    wait_idle();

    // Out-of-range start arguments are ignored.
    do_start(0, 2);
    chk("bad_cols0_busy", busy, 0);
    tick();
    chk("bad_cols0_busy_later", busy, 0);
    do_start(MAX_COLS + 1, 1);
    chk("bad_colsmax_busy", busy, 0);
    tick();
    chk("bad_colsmax_busy_later", busy, 0);
    do_start(2, 0);
    chk("bad_rows0_busy", busy, 0);

    // 3x4 with a 3-cycle downstream stall mid-row.
    run_model(3, 4, 40, 6, -1);

    // Start pulsed during RUN must not disturb the run.
    run_model(3, 3, 60, -1, 4);

    // Widest matrix.
    run_model(2, MAX_COLS, 30, -1, -1);

    // Reset in row 1 of a 3x3 run, then a clean 3x3 run.
    fill_rand(9, 50);
    model_push(3, 3);
    do_start(3, 3);
    stream(-1, -1, 4, f, l);
    rst = 1'b1;
    #1;
    check_reset_vals("midrun_reset");
    exp_q.delete();
    res_q.delete();
    last_res = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_model(3, 3, 50, -1, -1);

    // Randomized runs with random downstream backpressure.
    rand_bp = 1'b1;
    for (int n = 0; n < 10; n++) begin
      run_model(int'($urandom_range(1, 5)), int'($urandom_range(1, MAX_COLS)),
                (n % 2 == 0) ? 30 : 255, -1, -1);
    end
    rand_bp = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
